// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: op encodings, FSM states, op decode helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_access_pkg;

    localparam int BYTE_BUS_W = 8;

    // Memory op encodings carried down the ex_mem register.
    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LH   = 4'd2,
        MEM_OP_LW   = 4'd3,
        MEM_OP_LBU  = 4'd4,
        MEM_OP_LHU  = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Number of bytes moved by an op; 0 for anything that is not a memory op.
    function automatic logic [2:0] op_size(input logic [3:0] op);
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: op_size = 3'd1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: op_size = 3'd2;
            MEM_OP_LW, MEM_OP_SW:             op_size = 3'd4;
            default:                          op_size = 3'd0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        op_is_load = (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
                     (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        op_is_store = (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Sign/zero extension of an assembled load value to register width.
// Latency: combinational.
// Backpressure: none.
module mem_access_load_ext
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [31:0]     val_i,
    output logic [XLEN-1:0] res_o
);

    // Extend according to load width and signedness.
    always_comb begin
        res_o = '0;
        case (op_i)
            MEM_OP_LB:  res_o = {{(XLEN-8){val_i[7]}}, val_i[7:0]};
            MEM_OP_LBU: res_o = {{(XLEN-8){1'b0}}, val_i[7:0]};
            MEM_OP_LH:  res_o = {{(XLEN-16){val_i[15]}}, val_i[15:0]};
            MEM_OP_LHU: res_o = {{(XLEN-16){1'b0}}, val_i[15:0]};
            MEM_OP_LW:  res_o = XLEN'(val_i);
            default:    res_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: byte-serial loads/stores over a shared bus, ALU pass-through otherwise.
// Latency: pass-through combinational; memory op N bytes + 1 FINISH cycle with continuous grant.
// Backpressure: stall_req held while an access is in flight; bus_gnt=0 pauses byte issue.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        op_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   sdata_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              mem_we,
    output logic [REG_AW-1:0] mem_waddr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              stall_req,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] bus_a,
    output logic              bus_wr,
    output logic [7:0]        bus_dout,
    input  logic [7:0]        bus_din
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [2:0]        k_q, k_d;
    logic              pend_q, pend_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       asm_q, asm_d;

    logic [31:0]       asm_merged;
    logic [XLEN-1:0]   ext_res;

    logic              we_c, stall_c, req_c, wr_c;
    logic [REG_AW-1:0] waddr_c;
    logic [XLEN-1:0]   wdata_c;
    logic [ADDR_W-1:0] a_c;
    logic [7:0]        dout_c;

    // Fold the byte read back this cycle into its lane of the assembly register.
    always_comb begin
        asm_merged = asm_q;
        if (pend_q) begin
            asm_merged[{lane_q, 3'b000} +: 8] = bus_din;
        end
    end

    mem_access_load_ext #(.XLEN(XLEN)) u_load_ext (
        .op_i  (op_q),
        .val_i (asm_merged),
        .res_o (ext_res)
    );

    // Next-state, byte issue and result selection.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        waddr_d = waddr_q;
        k_d     = k_q;
        pend_d  = 1'b0;
        lane_d  = lane_q;
        asm_d   = asm_merged;
        we_c    = 1'b0;
        waddr_c = '0;
        wdata_c = '0;
        stall_c = 1'b0;
        req_c   = 1'b0;
        a_c     = '0;
        wr_c    = 1'b0;
        dout_c  = '0;
        case (state_q)
            ST_IDLE: begin
                if (op_is_load(op_i) || op_is_store(op_i)) begin
                    stall_c = 1'b1;
                    req_c   = 1'b1;
                    // ex_mem holds while stalled, so re-latching each waiting cycle is harmless.
                    op_d    = op_i;
                    addr_d  = addr_i;
                    sdata_d = sdata_i;
                    waddr_d = waddr_i;
                    asm_d   = '0;
                    if (bus_gnt) begin
                        a_c     = ADDR_W'(addr_i);
                        wr_c    = op_is_store(op_i);
                        dout_c  = wr_c ? sdata_i[7:0] : 8'h00;
                        pend_d  = op_is_load(op_i);
                        lane_d  = 2'd0;
                        k_d     = 3'd1;
                        state_d = (op_size(op_i) == 3'd1) ? ST_FINISH : ST_ACCESS;
                    end
                end else begin
                    we_c    = we_i;
                    waddr_c = waddr_i;
                    wdata_c = wdata_i;
                end
            end
            ST_ACCESS: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                if (bus_gnt) begin
                    a_c    = ADDR_W'(addr_q + XLEN'(k_q));
                    wr_c   = op_is_store(op_q);
                    dout_c = wr_c ? sdata_q[{k_q[1:0], 3'b000} +: 8] : 8'h00;
                    pend_d = op_is_load(op_q);
                    lane_d = k_q[1:0];
                    k_d    = k_q + 3'd1;
                    if (k_q + 3'd1 == op_size(op_q)) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                if (op_is_load(op_q)) begin
                    we_c    = 1'b1;
                    waddr_c = waddr_q;
                    wdata_c = ext_res;
                end
                k_d     = 3'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-operand registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            waddr_q <= '0;
            k_q     <= '0;
            pend_q  <= 1'b0;
            lane_q  <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            waddr_q <= waddr_d;
            k_q     <= k_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
        end
    end

    // Every output is forced low while reset is held, so an abandoned store writes nothing more.
    always_comb begin
        mem_we    = we_c & ~rst;
        mem_waddr = rst ? '0 : waddr_c;
        mem_wdata = rst ? '0 : wdata_c;
        stall_req = stall_c & ~rst;
        bus_req   = req_c & ~rst;
        bus_a     = rst ? '0 : a_c;
        bus_wr    = wr_c & ~rst;
        bus_dout  = rst ? '0 : dout_c;
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops against a byte-array memory model.
// Latency: n/a.
// Backpressure: exercises grant stalls (fixed gap and random).
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  op_i;
    logic [31:0] addr_i, sdata_i, wdata_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        stall_req, bus_req, bus_gnt, bus_wr;
    logic [31:0] bus_a;
    logic [7:0]  bus_dout, bus_din;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [logic [31:0]];

    mem_access #(.XLEN(32), .REG_AW(5), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .addr_i(addr_i), .sdata_i(sdata_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .stall_req(stall_req), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_a(bus_a), .bus_wr(bus_wr), .bus_dout(bus_dout), .bus_din(bus_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            MEM_OP_LW, MEM_OP_SW:             return 4;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
            default:                          return 1;
        endcase
    endfunction

    function automatic bit is_ld(input logic [3:0] op);
        return op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU};
    endfunction

    // Little-endian value from the model memory, then extension by plain arithmetic.
    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a);
        longint raw = 0;
        for (int i = 0; i < nbytes(op); i++) raw = raw + (longint'(rd(a + i)) << (8 * i));
        if (op == MEM_OP_LB && raw >= 128)   raw = raw - 256;
        if (op == MEM_OP_LH && raw >= 32768) raw = raw - 65536;
        return 32'(raw);
    endfunction

    // gmode: 0 = always granted, 1 = random grant, 2 = grant withheld 3 cycles after two bytes.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wa, input int gmode,
                         input bit has_want, input logic [31:0] want);
        int n = nbytes(op);
        bit ld = is_ld(op);
        int issued = 0, stall_cyc = 0, denied = 0, drop = 0, cycles = 0;
        bit done = 0, pend = 0;
        logic [31:0] pend_a = 0;
        logic [31:0] exp = has_want ? want : exp_load(op, a);
        while (!done && cycles < 60) begin
            @(negedge clk);
            op_i = op; addr_i = a; sdata_i = sd; we_i = ld; waddr_i = wa; wdata_i = $urandom;
            case (gmode)
                0: bus_gnt = 1'b1;
                1: bus_gnt = ($urandom_range(0, 3) != 0);
                default: begin
                    bus_gnt = !(issued == 2 && drop < 3);
                    if (!bus_gnt) drop++;
                end
            endcase
            bus_din = pend ? rd(pend_a) : 8'($urandom);
            #1;
            pend = 0;
            if (stall_req) begin
                stall_cyc++;
                check("stall_mem_we", {31'd0, mem_we}, 32'd0);
                if (bus_gnt) begin
                    check("bus_a", bus_a, a + issued);
                    check("bus_wr", {31'd0, bus_wr}, {31'd0, !ld});
                    if (!ld) begin
                        check("bus_dout", {24'd0, bus_dout}, {24'd0, 8'(sd >> (8 * issued))});
                        mem[bus_a] = bus_dout;
                    end else begin
                        pend = 1; pend_a = a + issued;
                    end
                    issued++;
                end else begin
                    denied++;
                    check("paused_bus_wr", {31'd0, bus_wr}, 32'd0);
                end
            end else begin
                check("fin_mem_we", {31'd0, mem_we}, {31'd0, ld});
                check("fin_bus_req", {31'd0, bus_req}, 32'd0);
                if (ld) begin
                    check("fin_wdata", mem_wdata, exp);
                    check("fin_waddr", {27'd0, mem_waddr}, {27'd0, wa});
                end
                check("bytes_issued", issued, n);
                check("stall_cycles", stall_cyc, n + denied);
                done = 1;
            end
            cycles++;
        end
        if (!done) check("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; op_i = MEM_OP_LW; addr_i = 32'h100; sdata_i = 0; we_i = 1'b1;
        waddr_i = 5'd3; wdata_i = 32'h55; bus_gnt = 1'b1; bus_din = 8'h00;
        @(posedge clk);
        @(negedge clk); #1;
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_bus_a", bus_a, 32'd0);

        // Pass-through of a non-memory op.
        @(negedge clk);
        rst = 1'b0; op_i = MEM_OP_NONE; we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'h1234;
        #1;
        check("pt_we", {31'd0, mem_we}, 32'd1);
        check("pt_waddr", {27'd0, mem_waddr}, 32'd5);
        check("pt_wdata", mem_wdata, 32'h1234);
        check("pt_stall", {31'd0, stall_req}, 32'd0);
        check("pt_bus_req", {31'd0, bus_req}, 32'd0);
        @(negedge clk);
        waddr_i = 5'd0; wdata_i = 32'h9;
        #1;
        check("pt_x0_we", {31'd0, mem_we}, 32'd1);
        check("pt_x0_waddr", {27'd0, mem_waddr}, 32'd0);

        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        mem[32'h110] = 8'h80;
        mem[32'h120] = 8'h00; mem[32'h121] = 8'h80;
        mem[32'h130] = 8'hDE; mem[32'h131] = 8'hAD; mem[32'h132] = 8'hBE; mem[32'h133] = 8'hEF;
        for (int i = 0; i < 4; i++) mem[32'h400 + i] = 8'h5A;
        for (int i = 0; i < 72; i++) mem[32'h300 + i] = 8'($urandom);

        do_op(MEM_OP_LW,  32'h100, 32'h0, 5'd7, 0, 1, 32'h44332211);
        do_op(MEM_OP_LB,  32'h110, 32'h0, 5'd8, 0, 1, 32'hFFFFFF80);
        do_op(MEM_OP_LBU, 32'h110, 32'h0, 5'd9, 0, 1, 32'h00000080);
        do_op(MEM_OP_LH,  32'h120, 32'h0, 5'd10, 0, 1, 32'hFFFF8000);
        do_op(MEM_OP_SH,  32'h203, 32'hAABBCCDD, 5'd0, 0, 0, 32'h0);
        check("sh_byte0", {24'd0, rd(32'h203)}, 32'hDD);
        check("sh_byte1", {24'd0, rd(32'h204)}, 32'hCC);
        do_op(MEM_OP_LW,  32'h130, 32'h0, 5'd11, 2, 1, 32'hEFBEADDE);
        do_op(MEM_OP_LHU, 32'h203, 32'h0, 5'd12, 1, 1, 32'h0000CCDD);

        // Randomized ops, mostly back-to-back, in a small address window.
        for (int t = 0; t < 40; t++) begin
            logic [3:0] op;
            op = 4'($urandom_range(1, 8));
            do_op(op, 32'h300 + $urandom_range(0, 64), $urandom, 5'($urandom), 1, 0, 32'h0);
        end

        // Reset during byte 2 of a store.
        @(negedge clk);
        op_i = MEM_OP_SW; addr_i = 32'h400; sdata_i = 32'h01020304; we_i = 1'b0; bus_gnt = 1'b1;
        #1;
        check("sw_b0_a", bus_a, 32'h400);
        check("sw_b0_wr", {31'd0, bus_wr}, 32'd1);
        if (bus_wr) mem[bus_a] = bus_dout;
        @(negedge clk); #1;
        check("sw_b1_a", bus_a, 32'h401);
        if (bus_wr) mem[bus_a] = bus_dout;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("sw_rst_wr", {31'd0, bus_wr}, 32'd0);
        check("sw_rst_stall", {31'd0, stall_req}, 32'd0);
        if (bus_wr) mem[bus_a] = bus_dout;
        @(negedge clk);
        rst = 1'b0; op_i = MEM_OP_NONE; we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'hCAFE;
        #1;
        check("post_rst_wr", {31'd0, bus_wr}, 32'd0);
        check("post_rst_stall", {31'd0, stall_req}, 32'd0);
        check("post_rst_we", {31'd0, mem_we}, 32'd1);
        check("post_rst_waddr", {27'd0, mem_waddr}, 32'd7);
        check("post_rst_wdata", mem_wdata, 32'hCAFE);
        if (bus_wr) mem[bus_a] = bus_dout;
        @(negedge clk); #1;
        check("post_rst2_wr", {31'd0, bus_wr}, 32'd0);
        check("sw_b0_mem", {24'd0, rd(32'h400)}, 32'h04);
        check("sw_b1_mem", {24'd0, rd(32'h401)}, 32'h03);
        check("sw_b2_untouched", {24'd0, rd(32'h402)}, 32'h5A);
        check("sw_b3_untouched", {24'd0, rd(32'h403)}, 32'h5A);

        // A load after the abandoned store still works from IDLE.
        do_op(MEM_OP_LW, 32'h100, 32'h0, 5'd13, 0, 1, 32'h44332211);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
